// File: rtl/pc_fetch_unit_if.sv
// Bus between the PC/fetch sequencer (master) and the datapath/memory side (slave).
// Carries redirect requests and handshakes in, and PC, memory and ALU controls out.
interface pc_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              stall;
   logic              exec_done;
   logic              jump;
   logic [ADDR_W-1:0] jump_target;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] pc_output;
   logic              mem_read;
   logic              IRWrite;
   logic              AluSourceA;
   logic              AluSourceB;
   logic [1:0]        AluOP;
   logic              misaligned;
   logic [15:0]       fetch_count;

   modport master (
      input  stall, exec_done, jump, jump_target, branch_taken, branch_target,
      output pc_output, mem_read, IRWrite, AluSourceA, AluSourceB, AluOP,
      output misaligned, fetch_count
   );

   modport slave (
      output stall, exec_done, jump, jump_target, branch_taken, branch_target,
      input  pc_output, mem_read, IRWrite, AluSourceA, AluSourceB, AluOP,
      input  misaligned, fetch_count
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and FETCH/WAIT/LATCH/EXEC sequencer for the multicycle datapath.
// Drives instruction-memory reads, IR load and PC-increment ALU controls; halts on a misaligned redirect.
module pc_fetch_unit #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                INCR         = 4,
   parameter int                MEM_LAT      = 1,
   parameter int                ALIGN_CHECK  = 1
) (
   input  logic           clock,
   input  logic           r_l,
   pc_fetch_unit_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_WAIT  = 3'd1,
      S_LATCH = 3'd2,
      S_EXEC  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic              mis, mis_nxt;
   logic [15:0]       fc, fc_nxt;

   logic [ADDR_W-1:0] target;
   logic              redirect;
   logic              target_bad;

   // Jump wins over branch; only a real redirect can be misaligned.
   always_comb begin
      target     = bus.jump ? bus.jump_target : bus.branch_target;
      redirect   = bus.jump | bus.branch_taken;
      target_bad = (ALIGN_CHECK != 0) && redirect && (target[1:0] != 2'b00);
   end

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      pc_nxt          = pc;
      mis_nxt         = mis;
      fc_nxt          = fc;
      bus.mem_read    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.AluSourceA  = 1'b0;
      bus.AluSourceB  = 1'b0;
      bus.AluOP       = 2'b00;

      unique case (state)
         S_FETCH, S_WAIT: bus.mem_read = 1'b1;
         S_LATCH: begin
            bus.IRWrite    = 1'b1;
            bus.AluSourceB = 1'b1;
         end
         S_EXEC: begin
            bus.AluSourceA = 1'b1;
            bus.AluOP      = 2'b10;
         end
         default: ;
      endcase

      if (!bus.stall) begin
         case (state)
            S_FETCH: begin
               state_nxt = S_WAIT;
               cnt_nxt   = CNT_LOAD;
            end
            S_WAIT: begin
               if (cnt != '0) cnt_nxt   = cnt - CNT_W'(1);
               else           state_nxt = S_LATCH;
            end
            S_LATCH: begin
               state_nxt = S_EXEC;
               pc_nxt    = pc + ADDR_W'(INCR);
               fc_nxt    = fc + 16'd1;
            end
            S_EXEC: begin
               if (bus.exec_done) begin
                  if (target_bad) begin
                     state_nxt = S_HALT;
                     mis_nxt   = 1'b1;
                  end else begin
                     state_nxt = S_FETCH;
                     if (redirect) pc_nxt = target;
                  end
               end
            end
            S_HALT:  ;
            default: state_nxt = S_HALT;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (r_l) begin
         state <= S_FETCH;
         cnt   <= '0;
         pc    <= RESET_VECTOR;
         mis   <= 1'b0;
         fc    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pc    <= pc_nxt;
         mis   <= mis_nxt;
         fc    <= fc_nxt;
      end
   end

   assign bus.pc_output   = pc;
   assign bus.misaligned  = mis;
   assign bus.fetch_count = fc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table on a MEM_LAT=1 instance plus
// hand sequences for halt, wrap-around, stall latency and mid-fetch reset (MEM_LAT=3).
module tb_pc_fetch_unit;

   localparam logic [5:0] C_FW = 6'b100000;  // {mem_read,IRWrite,AluSrcA,AluSrcB,AluOP}
   localparam logic [5:0] C_LA = 6'b010100;
   localparam logic [5:0] C_EX = 6'b001010;
   localparam logic [5:0] C_HA = 6'b000000;

   typedef struct {
      logic        stall, ed, j;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic [31:0] pc;
      logic [5:0]  ctrl;
      logic        mis;
      logic [15:0] fc;
   } vec_t;

   logic clock = 1'b0;
   logic r_l1, r_l3;
   int   checks   = 0;
   int   failures = 0;
   vec_t vecs[$];

   pc_fetch_unit_if #(.ADDR_W(32)) bus1 ();
   pc_fetch_unit_if #(.ADDR_W(32)) bus3 ();

   pc_fetch_unit #(.ADDR_W(32), .MEM_LAT(1)) u_dut1 (.clock(clock), .r_l(r_l1), .bus(bus1.master));
   pc_fetch_unit #(.ADDR_W(32), .MEM_LAT(3)) u_dut3 (.clock(clock), .r_l(r_l3), .bus(bus3.master));

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input bit sel3, input string tag, input logic [31:0] pc,
                             input logic [5:0] ctrl, input logic mis, input logic [15:0] fc);
      logic [31:0] a_pc;
      logic [5:0]  a_ctrl;
      logic        a_mis;
      logic [15:0] a_fc;
      if (sel3) begin
         a_pc   = bus3.pc_output;
         a_ctrl = {bus3.mem_read, bus3.IRWrite, bus3.AluSourceA, bus3.AluSourceB, bus3.AluOP};
         a_mis  = bus3.misaligned;
         a_fc   = bus3.fetch_count;
      end else begin
         a_pc   = bus1.pc_output;
         a_ctrl = {bus1.mem_read, bus1.IRWrite, bus1.AluSourceA, bus1.AluSourceB, bus1.AluOP};
         a_mis  = bus1.misaligned;
         a_fc   = bus1.fetch_count;
      end
      check({tag, " pc"},   a_pc, pc);
      check({tag, " ctrl"}, 32'(a_ctrl), 32'(ctrl));
      check({tag, " mis"},  32'(a_mis), 32'(mis));
      check({tag, " fc"},   32'(a_fc), 32'(fc));
   endtask

   task automatic drive1(input logic s, ed, j, input logic [31:0] jt, input logic br, input logic [31:0] bt);
      bus1.stall         = s;
      bus1.exec_done     = ed;
      bus1.jump          = j;
      bus1.jump_target   = jt;
      bus1.branch_taken  = br;
      bus1.branch_target = bt;
   endtask

   function automatic vec_t mk(input logic s, ed, j, input logic [31:0] jt, input logic br,
                               input logic [31:0] bt, input logic [31:0] pc, input logic [5:0] ctrl,
                               input logic mis, input logic [15:0] fc);
      vec_t v;
      v.stall = s; v.ed = ed; v.j = j; v.jt = jt; v.br = br; v.bt = bt;
      v.pc = pc; v.ctrl = ctrl; v.mis = mis; v.fc = fc;
      return v;
   endfunction

   // Count edges until IRWrite rises, bounded so a stuck FSM still reaches the summary.
   task automatic wait_latch3(inout int n);
      while (!bus3.IRWrite && n < 20) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      // Rows: inputs for the coming edge, then expected outputs after that edge.
      vecs.push_back(mk(0,1,0,0,0,0,          32'h0,   C_FW,0,0)); // WAIT
      vecs.push_back(mk(0,1,0,0,0,0,          32'h0,   C_LA,0,0));
      vecs.push_back(mk(0,1,0,0,0,0,          32'h4,   C_EX,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,          32'h4,   C_FW,0,1)); // FETCH pc=4
      vecs.push_back(mk(0,1,0,0,0,0,          32'h4,   C_FW,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,          32'h4,   C_LA,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,          32'h8,   C_EX,0,2));
      vecs.push_back(mk(0,1,0,0,0,0,          32'h8,   C_FW,0,2)); // FETCH pc=8
      vecs.push_back(mk(0,1,0,0,0,0,          32'h8,   C_FW,0,2));
      vecs.push_back(mk(0,1,0,0,0,0,          32'h8,   C_LA,0,2));
      vecs.push_back(mk(0,1,0,0,0,0,          32'hC,   C_EX,0,3));
      vecs.push_back(mk(0,1,1,32'h100,1,32'h200, 32'h100, C_FW,0,3)); // jump beats branch
      vecs.push_back(mk(0,0,0,0,0,0,          32'h100, C_FW,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,          32'h100, C_LA,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,          32'h104, C_EX,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,          32'h104, C_EX,0,4)); // waits for exec_done
      vecs.push_back(mk(1,1,1,32'h300,0,0,    32'h104, C_EX,0,4)); // stall beats exec_done
      vecs.push_back(mk(0,1,0,0,1,32'h40,     32'h40,  C_FW,0,4)); // branch
      vecs.push_back(mk(1,0,0,0,0,0,          32'h40,  C_FW,0,4)); // stalled in FETCH
      vecs.push_back(mk(0,0,0,0,0,0,          32'h40,  C_FW,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,          32'h40,  C_LA,0,4));
      vecs.push_back(mk(1,0,0,0,0,0,          32'h40,  C_LA,0,4)); // IRWrite held by stall
      vecs.push_back(mk(0,0,0,0,0,0,          32'h44,  C_EX,0,5));
      vecs.push_back(mk(0,1,1,32'h46,1,32'h80, 32'h44, C_HA,1,5)); // misaligned jump wins
      vecs.push_back(mk(0,1,1,32'h200,0,0,    32'h44,  C_HA,1,5));
      vecs.push_back(mk(0,1,0,0,1,32'h300,    32'h44,  C_HA,1,5));

      drive1(0,0,0,0,0,0);
      bus3.stall = 0; bus3.exec_done = 1; bus3.jump = 0; bus3.jump_target = 0;
      bus3.branch_taken = 0; bus3.branch_target = 0;
      r_l1 = 1; r_l3 = 1;
      tick();
      check_outs(0, "reset1", 32'h0, C_FW, 0, 0);
      check_outs(1, "reset3", 32'h0, C_FW, 0, 0);
      r_l1 = 0; r_l3 = 0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive1(vecs[i].stall, vecs[i].ed, vecs[i].j, vecs[i].jt, vecs[i].br, vecs[i].bt);
         tick();
         check_outs(0, $sformatf("vec%0d", i), vecs[i].pc, vecs[i].ctrl, vecs[i].mis, vecs[i].fc);
      end

      // Misaligned branch from the first instruction; reset is the only way out of HALT.
      r_l1 = 1; drive1(0,0,0,0,0,0);
      tick();
      check_outs(0, "halt_reset", 32'h0, C_FW, 0, 0);
      r_l1 = 0; drive1(0,1,0,0,0,0);
      tick(); tick(); tick();
      check_outs(0, "t4_exec", 32'h4, C_EX, 0, 1);
      drive1(0,1,0,0,1,32'h102);
      tick();
      check_outs(0, "t4_halt", 32'h4, C_HA, 1, 1);
      for (int i = 0; i < 3; i++) begin
         drive1(0,1,1,32'h200,0,0);
         tick();
         check_outs(0, $sformatf("t4_hold%0d", i), 32'h4, C_HA, 1, 1);
      end
      r_l1 = 1; drive1(0,0,0,0,0,0);
      tick();
      check_outs(0, "t4_reset", 32'h0, C_FW, 0, 0);
      r_l1 = 0;

      // PC wrap-around at LATCH.
      drive1(0,1,0,0,0,0);
      tick(); tick(); tick();
      drive1(0,1,1,32'hFFFF_FFFC,0,0);
      tick();
      check_outs(0, "t5_fetch", 32'hFFFF_FFFC, C_FW, 0, 1);
      drive1(0,1,0,0,0,0);
      tick(); tick();
      check_outs(0, "t5_latch", 32'hFFFF_FFFC, C_LA, 0, 1);
      tick();
      check_outs(0, "t5_wrap", 32'h0, C_EX, 0, 2);

      // MEM_LAT=3: baseline fetch latency, then a 3-cycle stall inside WAIT.
      r_l3 = 1;
      tick();
      r_l3 = 0;
      n = 0;
      wait_latch3(n);
      check("t3_base_latency", 32'(n), 32'd4);
      tick();
      check_outs(1, "t3_exec", 32'h4, C_EX, 0, 1);
      tick();
      check_outs(1, "t3_fetch", 32'h4, C_FW, 0, 1);
      n = 0;
      tick(); n++;
      tick(); n++;
      bus3.stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick(); n++;
         check_outs(1, $sformatf("t3_stall%0d", i), 32'h4, C_FW, 0, 1);
      end
      bus3.stall = 0;
      wait_latch3(n);
      check("t3_stall_latency", 32'(n), 32'd7);
      check_outs(1, "t3_latch", 32'h4, C_LA, 0, 1);

      // Reset asserted mid-fetch while in WAIT.
      tick();
      tick();
      tick();
      check_outs(1, "t6_wait", 32'h8, C_FW, 0, 2);
      r_l3 = 1;
      tick();
      check_outs(1, "t6_reset", 32'h0, C_FW, 0, 0);
      r_l3 = 0;
      n = 0;
      wait_latch3(n);
      check("t6_restart_latency", 32'(n), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
